// File: rtl/tetris_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tetris_ctrl_pkg
// Shared control definitions between the input controller and the game core.
//   control_type : command word presented to the core (NONE = idle).
//   NUM_BTN      : number of physical buttons, bit i maps to command i+1.
//   btn_to_cmd   : button index -> command.
// ---------------------------------------------------------------------------
package tetris_ctrl_pkg;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        LEFT       = 4'd1,
        RIGHT      = 4'd2,
        DOWN       = 4'd3,
        DROP       = 4'd4,
        HOLD       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        BAR        = 4'd8
    } control_type;

    localparam int NUM_BTN = 8;

    function automatic control_type btn_to_cmd(input logic [2:0] idx);
        return control_type'({1'b0, idx} + 4'd1);
    endfunction

endpackage

// File: rtl/tetris_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchronizer, debouncer and optional
// auto-repeat (DAS delay then ARR period while held).
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high
//   btn_raw : raw asynchronous button level
//   evt     : single-cycle event (press or auto-repeat)
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DAS_CYCLES      = 17_000_000,
    parameter int ARR_CYCLES      = 5_000_000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic evt
);

    localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW_DAS = (DAS_CYCLES > 1) ? $clog2(DAS_CYCLES) : 1;
    localparam int RW_ARR = (ARR_CYCLES > 1) ? $clog2(ARR_CYCLES) : 1;
    localparam int RW     = (RW_DAS > RW_ARR) ? RW_DAS : RW_ARR;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DAS_LAST = RW'(DAS_CYCLES - 1);
    localparam logic [RW-1:0] ARR_LAST = RW'(ARR_CYCLES - 1);

    logic          sync1, sync2;
    logic [1:0]    sync_vld;
    logic [DW-1:0] db_cnt;
    logic          level, level_q;
    logic          armed;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_last;
    logic          in_arr;
    logic          held, press, rep_fire;

    // held: level was already 1 last cycle, so the press cycle itself
    // does not count toward the repeat delay.
    assign held     = level & level_q;
    assign press    = armed & level & ~level_q;
    assign rep_last = in_arr ? ARR_LAST : DAS_LAST;
    assign rep_fire = REPEAT_EN & armed & held & (rep_cnt == rep_last);
    assign evt      = press | rep_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_vld <= 2'b00;
            db_cnt   <= '0;
            level    <= 1'b0;
            level_q  <= 1'b0;
            armed    <= 1'b0;
            rep_cnt  <= '0;
            in_arr   <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};

            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            level_q <= level;

            // After reset the channel stays disarmed until a real released
            // level has been seen, so a button held through reset is ignored
            // until it is let go and pressed again.
            if (sync_vld[1] && !sync2 && !level)
                armed <= 1'b1;

            if (!held || !armed || !REPEAT_EN) begin
                rep_cnt <= '0;
                in_arr  <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt <= '0;
                in_arr  <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_ctrl.sv
// ---------------------------------------------------------------------------
// tetris_ctrl
// Turns raw buttons and a gravity timer into one command at a time for the
// game core.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high
//   btn     : raw buttons, bit i -> command i+1 (LEFT..BAR)
//   ready   : core accepts a command this cycle
//   score   : 4-digit BCD score, hundreds digit selects gravity speed
//   ctrl    : registered command to the core, NONE when idle
//   dropped : one-cycle pulse when a button event is discarded
// ---------------------------------------------------------------------------
module tetris_ctrl
    import tetris_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DAS_CYCLES      = 17_000_000,
    parameter int ARR_CYCLES      = 5_000_000,
    parameter int GRAVITY_CYCLES  = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        btn,
    input  logic              ready,
    input  logic [15:0]       score,
    output control_type       ctrl,
    output logic              dropped
);

    localparam int GW = (GRAVITY_CYCLES > 1) ? $clog2(GRAVITY_CYCLES) : 1;

    // ---------------- button channels ----------------
    logic [NUM_BTN-1:0] evt;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_btn
            // Only LEFT, RIGHT, DOWN auto-repeat.
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .DAS_CYCLES      (DAS_CYCLES),
                .ARR_CYCLES      (ARR_CYCLES),
                .REPEAT_EN       ((i <= 2) ? 1'b1 : 1'b0)
            ) u_db (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (btn[i]),
                .evt     (evt[i])
            );
        end
    endgenerate

    // ---------------- arbiter: lowest index wins ----------------
    logic [2:0] win_idx;
    logic       any_evt;
    logic       multi_evt;

    always_comb begin
        win_idx = 3'd0;
        any_evt = 1'b0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (evt[k]) begin
                win_idx = 3'(k);
                any_evt = 1'b1;
            end
        end
        multi_evt = (evt & (evt - 8'd1)) != 8'd0;
    end

    // ---------------- gravity ----------------
    logic [2:0]    grav_shift;
    logic [31:0]   grav_period;
    logic [GW-1:0] grav_last;
    logic [GW-1:0] grav_cnt;
    logic          grav_flag;
    logic          grav_expire;
    logic          unused_score;

    assign unused_score = ^{score[15:12], score[7:0]};
    assign grav_shift   = (score[11:8] > 4'd4) ? 3'd4 : score[10:8];
    assign grav_period  = 32'(GRAVITY_CYCLES) >> grav_shift;
    assign grav_last    = (grav_period > 32'd1) ? GW'(grav_period - 32'd1) : '0;
    // >= rather than == so a faster period after a score change takes
    // effect immediately instead of waiting for a wrap.
    assign grav_expire  = ready & (grav_cnt >= grav_last) & ~grav_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            grav_cnt <= '0;
        end else if (ready) begin
            if (grav_cnt >= grav_last)
                grav_cnt <= grav_flag ? grav_last : '0;
            else
                grav_cnt <= grav_cnt + 1'b1;
        end
    end

    // ---------------- pending slot and presentation ----------------
    logic        slot_full, slot_full_nx;
    control_type slot_cmd, slot_cmd_nx;
    logic        flag_nx;
    logic        ctrl_user;      // ctrl currently shows the slot, not gravity
    logic        consume, consume_slot, consume_flag;
    logic        slot_open;
    logic        drop_nx;
    control_type ctrl_nx;

    assign consume      = ready & (ctrl != NONE);
    assign consume_slot = consume & ctrl_user;
    assign consume_flag = consume & ~ctrl_user;
    // A slot being consumed this edge can take a new event in the same edge.
    assign slot_open    = ~slot_full | consume_slot;
    assign flag_nx      = (grav_flag & ~consume_flag) | grav_expire;
    assign drop_nx      = multi_evt | (any_evt & ~slot_open);

    always_comb begin
        slot_full_nx = slot_full;
        slot_cmd_nx  = slot_cmd;
        if (consume_slot)
            slot_full_nx = 1'b0;
        if (any_evt && slot_open) begin
            slot_full_nx = 1'b1;
            slot_cmd_nx  = btn_to_cmd(win_idx);
        end
    end

    // ctrl is built from next state so a new source shows on the same edge
    // it is captured.
    assign ctrl_nx = slot_full_nx ? slot_cmd_nx : (flag_nx ? DOWN : NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full <= 1'b0;
            slot_cmd  <= NONE;
            grav_flag <= 1'b0;
            ctrl      <= NONE;
            ctrl_user <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            slot_full <= slot_full_nx;
            slot_cmd  <= slot_cmd_nx;
            grav_flag <= flag_nx;
            dropped   <= drop_nx;
            // A shown command is frozen until the core takes it.
            if (ready || ctrl == NONE) begin
                ctrl      <= ctrl_nx;
                ctrl_user <= slot_full_nx;
            end
        end
    end

endmodule

// File: tb/tb_tetris_ctrl.sv
module tb_tetris_ctrl;
    import tetris_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  btn;
    logic        ready;
    logic [15:0] score;
    control_type ctrl;
    logic        dropped;

    int total = 0;
    int bad   = 0;

    tetris_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DAS_CYCLES      (20),
        .ARR_CYCLES      (8),
        .GRAVITY_CYCLES  (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .ready   (ready),
        .score   (score),
        .ctrl    (ctrl),
        .dropped (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  b;
        logic        rdy;
        int          n;
        control_type exp_ctrl;
        logic        exp_drop;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [7:0] b, input logic rd,
                                input int n, input control_type ec, input logic ed,
                                input string nm);
        vec_t v;
        v.rst = r; v.b = b; v.rdy = rd; v.n = n;
        v.exp_ctrl = ec; v.exp_drop = ed; v.name = nm;
        tbl.push_back(v);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ctrl(input control_type cmd, input int limit, output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (ctrl != cmd && cyc < limit);
        if (ctrl != cmd) begin
            total++;
            bad++;
            $display("FAIL wait_%s: not seen within %0d cycles", cmd.name(), limit);
        end
    endtask

    int c;
    int hits[$];
    int exp_hits[6] = '{7, 27, 35, 43, 51, 59};

    initial begin
        reset = 1'b1; btn = 8'h00; ready = 1'b0; score = 16'h0000;

        // single press, consumed immediately
        add(1, 8'h00, 1, 2,  NONE,   0, "rst_state");
        add(0, 8'h00, 1, 4,  NONE,   0, "idle");
        add(0, 8'h20, 1, 6,  NONE,   0, "rot_pre");
        add(0, 8'h20, 1, 1,  ROTATE, 0, "rot_show");
        add(0, 8'h20, 1, 1,  NONE,   0, "rot_consumed");
        add(0, 8'h20, 1, 2,  NONE,   0, "rot_hold");
        add(0, 8'h00, 1, 10, NONE,   0, "rot_release");
        // 3-cycle glitch rejected
        add(1, 8'h00, 1, 2,  NONE,   0, "rst2");
        add(0, 8'h00, 1, 4,  NONE,   0, "idle2");
        add(0, 8'h01, 1, 3,  NONE,   0, "glitch_hi");
        add(0, 8'h00, 1, 4,  NONE,   0, "glitch_slot");
        add(0, 8'h00, 1, 6,  NONE,   0, "glitch_after");
        // ready low: ctrl holds, second press dropped
        add(1, 8'h00, 0, 2,  NONE,   0, "rst3");
        add(0, 8'h00, 0, 4,  NONE,   0, "idle3");
        add(0, 8'h08, 0, 7,  DROP,   0, "drop_show");
        add(0, 8'h08, 0, 3,  DROP,   0, "drop_hold");
        add(0, 8'h0A, 0, 6,  DROP,   0, "right_pre");
        add(0, 8'h0A, 0, 1,  DROP,   1, "right_dropped");
        add(0, 8'h0A, 0, 1,  DROP,   0, "drop_pulse_end");
        add(0, 8'h0A, 1, 1,  NONE,   0, "drop_consumed");
        add(0, 8'h00, 1, 8,  NONE,   0, "release3");
        // event lands in the consumption cycle
        add(1, 8'h00, 0, 2,  NONE,   0, "rst4");
        add(0, 8'h00, 0, 4,  NONE,   0, "idle4");
        add(0, 8'h08, 0, 7,  DROP,   0, "drop_show2");
        add(0, 8'h28, 0, 6,  DROP,   0, "rot_pending");
        add(0, 8'h28, 1, 1,  ROTATE, 0, "same_cycle_accept");
        add(0, 8'h28, 1, 1,  NONE,   0, "rot_consumed2");
        add(0, 8'h00, 1, 8,  NONE,   0, "release4");
        // simultaneous events, then reset while held
        add(1, 8'h00, 1, 2,  NONE,   0, "rst5");
        add(0, 8'h00, 1, 4,  NONE,   0, "idle5");
        add(0, 8'h44, 1, 6,  NONE,   0, "dual_pre");
        add(0, 8'h44, 1, 1,  DOWN,   1, "dual_down");
        add(0, 8'h44, 1, 1,  NONE,   0, "dual_drop_end");
        add(1, 8'h04, 1, 2,  NONE,   0, "rst_held");
        add(0, 8'h04, 1, 7,  NONE,   0, "held_no_press");
        add(0, 8'h04, 1, 20, NONE,   0, "held_no_repeat");
        add(0, 8'h00, 1, 12, NONE,   0, "held_release");
        add(0, 8'h04, 1, 7,  DOWN,   0, "repress");
        add(0, 8'h04, 1, 1,  NONE,   0, "repress_consumed");

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            btn   = tbl[i].b;
            ready = tbl[i].rdy;
            step(tbl[i].n);
            chk({tbl[i].name, "_ctrl"}, 32'(ctrl), 32'(tbl[i].exp_ctrl));
            chk({tbl[i].name, "_drop"}, 32'(dropped), 32'(tbl[i].exp_drop));
        end

        // LEFT held 60 cycles: press, then DAS, then ARR repeats
        reset = 1'b1; btn = 8'h00; ready = 1'b1; score = 16'h0000;
        step(2);
        reset = 1'b0;
        step(4);
        btn = 8'h01;
        for (int k = 1; k <= 80; k++) begin
            step(1);
            if (ctrl == LEFT) hits.push_back(k);
            if (k == 60) btn = 8'h00;
        end
        chk("left_count", 32'(hits.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < hits.size())
                chk($sformatf("left_evt%0d", k), 32'(hits[k]), 32'(exp_hits[k]));

        // gravity periods and freeze
        reset = 1'b1; btn = 8'h00; ready = 1'b1; score = 16'h0000;
        step(2);
        reset = 1'b0;
        wait_ctrl(DOWN, 300, c); chk("grav_first", 32'(c), 32'd100);
        wait_ctrl(DOWN, 300, c); chk("grav_l0", 32'(c), 32'd100);
        step(10);
        ready = 1'b0;
        step(50);
        ready = 1'b1;
        wait_ctrl(DOWN, 300, c); chk("grav_freeze", 32'(c), 32'd90);
        score = 16'h0300;
        wait_ctrl(DOWN, 300, c);
        wait_ctrl(DOWN, 300, c); chk("grav_l3_a", 32'(c), 32'd12);
        wait_ctrl(DOWN, 300, c); chk("grav_l3_b", 32'(c), 32'd12);
        score = 16'h0900;
        wait_ctrl(DOWN, 300, c);
        wait_ctrl(DOWN, 300, c); chk("grav_l9", 32'(c), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
